// File: rtl/prog_loader_ctrl.sv
// ---------------------------------------------------------------------------
// prog_loader_ctrl
//
// Loads a pipelined MIPS core before it runs, then runs it for a fixed budget:
//   1. writes every architectural register (index pattern or stream words),
//   2. writes the program from the stream into instruction memory,
//   3. NOP-fills the rest of instruction memory,
//   4. keeps the core in reset for RST_HOLD cycles,
//   5. releases the core for RUN_CYCLES cycles, then reports done.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start, reg_src      begin a sequence (only in IDLE/DONE); register source select
//   s_valid/s_ready/s_data/s_last
//                       host word stream. A word moves only in a cycle where
//                       s_valid && s_ready. s_ready depends on state alone and
//                       never on s_valid. The host may stall at any time.
//   rf_we/rf_addr/rf_wdata        register file write port (registered)
//   imem_we/imem_addr/imem_wdata  instruction memory write port (registered)
//   core_rst            active-high reset to the core (low only while running)
//   busy, done, ovf     status; ovf is sticky until the next start
//   inst_count          number of instruction words accepted
//   cycle_cnt           core run cycles elapsed (saturating)
//   dbgState            current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module prog_loader_ctrl #(
   parameter int DATA_W     = 32,
   parameter int IMEM_AW    = 16,
   parameter int NREGS      = 32,
   parameter int RST_HOLD   = 2,
   parameter int RUN_CYCLES = 40,
   parameter int CNT_W      = 16,
   localparam int RF_AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               reg_src,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DATA_W-1:0]  s_data,
   input  logic               s_last,
   output logic               rf_we,
   output logic [RF_AW-1:0]   rf_addr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [DATA_W-1:0]  imem_wdata,
   output logic               core_rst,
   output logic               busy,
   output logic               done,
   output logic               ovf,
   output logic [IMEM_AW:0]   inst_count,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [2:0]         dbgState
);

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int RUN_W  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [RUN_W-1:0]   RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
   localparam logic [RF_AW-1:0]   LAST_REG  = RF_AW'(NREGS - 1);
   localparam logic [IMEM_AW-1:0] LAST_ADDR = {IMEM_AW{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REGS = 3'd1,
      INST = 3'd2,
      FILL = 3'd3,
      HOLD = 3'd4,
      RUN  = 3'd5,
      DONE = 3'd6
   } stateE;

   stateE              state;
   stateE              stateNext;

   // register source is captured at start so a mid-load change cannot
   // mix the two register patterns
   logic               regSrcQ;
   logic [RF_AW-1:0]   regIdx;
   logic [IMEM_AW-1:0] fillAddr;
   logic [HOLD_W-1:0]  holdCnt;
   logic [RUN_W-1:0]   runCnt;

   // decisions made this cycle, turned into registered write strobes
   logic               startHit;
   logic               rfWeNext;
   logic [DATA_W-1:0]  rfDataNext;
   logic               imWeNext;
   logic [IMEM_AW-1:0] imAddrNext;
   logic [DATA_W-1:0]  imDataNext;
   logic               ovfSet;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // -------------------------------------------------------------------------
   // Next state, status outputs and write decisions
   // -------------------------------------------------------------------------
   always_comb begin
      stateNext  = state;
      s_ready    = 1'b0;
      core_rst   = 1'b1;
      busy       = 1'b1;
      done       = 1'b0;
      startHit   = 1'b0;
      rfWeNext   = 1'b0;
      rfDataNext = '0;
      imWeNext   = 1'b0;
      imAddrNext = inst_count[IMEM_AW-1:0];
      imDataNext = '0;
      ovfSet     = 1'b0;

      case (state)
         IDLE, DONE: begin
            busy = 1'b0;
            done = (state == DONE);
            if (start) begin
               startHit  = 1'b1;
               stateNext = REGS;
            end
         end

         REGS: begin
            if (regSrcQ) begin
               s_ready = 1'b1;
               if (s_valid) begin
                  rfWeNext   = 1'b1;
                  rfDataNext = s_data;
               end
            end else begin
               rfWeNext   = 1'b1;
               rfDataNext = DATA_W'(regIdx);
            end
            if (rfWeNext && (regIdx == LAST_REG)) begin
               stateNext = INST;
            end
         end

         INST: begin
            s_ready = 1'b1;
            if (s_valid) begin
               imWeNext   = 1'b1;
               imDataNext = s_data;
               // the top address ends loading either way; without s_last
               // the program did not fit and the tail is dropped
               if (inst_count[IMEM_AW-1:0] == LAST_ADDR) begin
                  ovfSet    = !s_last;
                  stateNext = HOLD;
               end else if (s_last) begin
                  stateNext = FILL;
               end
            end
         end

         FILL: begin
            imWeNext   = 1'b1;
            imAddrNext = fillAddr;
            if (fillAddr == LAST_ADDR) begin
               stateNext = HOLD;
            end
         end

         HOLD: begin
            if (holdCnt == HOLD_LAST) begin
               stateNext = RUN;
            end
         end

         RUN: begin
            core_rst = 1'b0;
            if (runCnt == RUN_LAST) begin
               stateNext = DONE;
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign dbgState = state;

   // -------------------------------------------------------------------------
   // Counters, sticky flag and registered write ports
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regSrcQ    <= 1'b0;
         regIdx     <= '0;
         fillAddr   <= '0;
         holdCnt    <= '0;
         runCnt     <= '0;
         inst_count <= '0;
         cycle_cnt  <= '0;
         ovf        <= 1'b0;
         rf_we      <= 1'b0;
         rf_addr    <= '0;
         rf_wdata   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         rf_we   <= rfWeNext;
         imem_we <= imWeNext;
         if (rfWeNext) begin
            rf_addr  <= regIdx;
            rf_wdata <= rfDataNext;
         end
         if (imWeNext) begin
            imem_addr  <= imAddrNext;
            imem_wdata <= imDataNext;
         end

         if (startHit) begin
            regSrcQ    <= reg_src;
            regIdx     <= '0;
            fillAddr   <= '0;
            holdCnt    <= '0;
            runCnt     <= '0;
            inst_count <= '0;
            cycle_cnt  <= '0;
            ovf        <= 1'b0;
         end else begin
            case (state)
               REGS: begin
                  if (rfWeNext) begin
                     regIdx <= regIdx + 1'b1;
                  end
               end
               INST: begin
                  if (imWeNext) begin
                     inst_count <= inst_count + 1'b1;
                     // fill resumes right after the last program word
                     fillAddr   <= inst_count[IMEM_AW-1:0] + 1'b1;
                     if (ovfSet) begin
                        ovf <= 1'b1;
                     end
                  end
               end
               FILL: fillAddr <= fillAddr + 1'b1;
               HOLD: holdCnt  <= holdCnt + 1'b1;
               RUN: begin
                  runCnt <= runCnt + 1'b1;
                  if (cycle_cnt != CNT_MAX) begin
                     cycle_cnt <= cycle_cnt + 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
`timescale 1ns/1ps
module tb_prog_loader_ctrl;
  localparam int DATA_W     = 32;
  localparam int IMEM_AW    = 4;
  localparam int NREGS      = 32;
  localparam int RST_HOLD   = 2;
  localparam int RUN_CYCLES = 40;
  localparam int CNT_W      = 5;
  localparam int RF_AW      = 5;
  localparam int DEPTH      = 1 << IMEM_AW;
  localparam int SAT        = (1 << CNT_W) - 1;
  localparam int TR         = 512;
  localparam logic [DATA_W-1:0] SENT = 32'hDEAD_BEEF;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, start, reg_src, s_valid, s_ready, s_last;
  logic [DATA_W-1:0] s_data;
  logic rf_we, imem_we, core_rst, busy, done, ovf;
  logic [RF_AW-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata, imem_wdata;
  logic [IMEM_AW-1:0] imem_addr;
  logic [IMEM_AW:0] inst_count;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  prog_loader_ctrl #(
    .DATA_W(DATA_W), .IMEM_AW(IMEM_AW), .NREGS(NREGS),
    .RST_HOLD(RST_HOLD), .RUN_CYCLES(RUN_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .reg_src(reg_src),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .ovf(ovf),
    .inst_count(inst_count), .cycle_cnt(cycle_cnt), .dbgState(dbg_state)
  );

  // ---------------- shared bench state ----------------
  int errors, checks;
  logic [DATA_W-1:0] strm_q[$];
  bit                last_q[$];
  int                stall_mode;
  logic [DATA_W-1:0] exp_q[$];   // expected register file writes, in order

  int   cyc;                      // cycles since the launching start edge
  logic rst_tr[TR], done_tr[TR], ready_tr[TR], hs_tr[TR];
  logic [CNT_W-1:0] cc_tr[TR];
  logic [RF_AW-1:0]  rf_a_q[$];
  logic [DATA_W-1:0] rf_d_q[$];
  int   rf_nohs;
  logic [DATA_W-1:0] imem_m[DEPTH];
  int   im_wr_cnt, last_im_wr;

  // ---------------- stream driver ----------------
  initial begin : stream_driver
    bit hs;
    bit tog;
    logic [DATA_W-1:0] d;
    bit l;
    tog = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (hs && strm_q.size() > 0) begin
        d = strm_q.pop_front();
        l = last_q.pop_front();
      end
      tog = ~tog;
      if (strm_q.size() > 0 && (stall_mode == 0 || tog)) begin
        s_valid = 1'b1; s_data = strm_q[0]; s_last = last_q[0];
      end else begin
        s_valid = 1'b0; s_data = $urandom; s_last = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    if (cyc >= 0 && cyc < TR) begin
      rst_tr[cyc]   = core_rst;
      done_tr[cyc]  = done;
      ready_tr[cyc] = s_ready;
      hs_tr[cyc]    = s_valid && s_ready;
      cc_tr[cyc]    = cycle_cnt;
      if (rf_we === 1'b1) begin
        rf_a_q.push_back(rf_addr);
        rf_d_q.push_back(rf_wdata);
        if (cyc == 0) rf_nohs++;
        else if (hs_tr[cyc-1] !== 1'b1) rf_nohs++;
      end
      if (imem_we === 1'b1) begin
        imem_m[imem_addr] = imem_wdata;
        im_wr_cnt++;
        last_im_wr = cyc;
      end
      cyc++;
    end
  end

  // ---------------- reference model helpers ----------------
  // Cycle (relative to the start edge) at which the core leaves reset for a
  // stall-free load of l words: NREGS + loaded words + fill + hold.
  function automatic int run_start(input int l);
    int nw;
    nw = (l < DEPTH) ? l : DEPTH;
    return NREGS + nw + (DEPTH - nw) + RST_HOLD;
  endfunction

  function automatic int first_rst_low();
    for (int c = 0; c < TR; c++) if (rst_tr[c] === 1'b0) return c;
    return -1;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cc(input int k);
    return CNT_W'((k > SAT) ? SAT : k);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_words(input int n, input bit with_last, output logic [DATA_W-1:0] w[$]);
    w.delete();
    for (int i = 0; i < n; i++) begin
      w.push_back($urandom);
      strm_q.push_back(w[i]);
      last_q.push_back(with_last && (i == n - 1));
    end
  endtask

  task automatic flush_stream();
    strm_q.delete();
    last_q.delete();
  endtask

  task automatic launch(input bit src);
    rf_a_q.delete(); rf_d_q.delete(); rf_nohs = 0;
    im_wr_cnt = 0; last_im_wr = -1;
    for (int a = 0; a < DEPTH; a++) imem_m[a] = SENT;
    for (int c = 0; c < TR; c++) begin
      rst_tr[c] = 1'b1; done_tr[c] = 1'b0; ready_tr[c] = 1'b0; hs_tr[c] = 1'b0; cc_tr[c] = '0;
    end
    cyc = TR;
    @(posedge clk); #1;
    start = 1'b1; reg_src = src;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        dc = cyc - 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    checks++;
    if ({s_ready, rf_we, imem_we, busy, done, ovf} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {s_ready, rf_we, imem_we, busy, done, ovf});
    end
    checks++;
    if ({inst_count, cycle_cnt, rf_addr, rf_wdata, imem_addr, imem_wdata} !== '0) begin
      errors++; $display("FAIL reset_buses: inst_count=%0d cycle_cnt=%0d rf_addr=%0d imem_addr=%0d want all 0",
                         inst_count, cycle_cnt, rf_addr, imem_addr);
    end
    rst = 1'b1;
  endtask

  task automatic test_identity();
    logic [DATA_W-1:0] w[$];
    int l, r, dc, bad;
    logic [DATA_W-1:0] e;
    l = 15;
    stall_mode = 0;
    push_words(l, 1'b1, w);
    exp_q.delete();
    for (int i = 0; i < NREGS; i++) exp_q.push_back(DATA_W'(i));
    launch(1'b0);
    wait_done(400, dc);
    r = run_start(l);
    checks++; if (dc !== r + RUN_CYCLES) begin errors++; $display("FAIL ident_done_cycle: got %0d want %0d", dc, r + RUN_CYCLES); end
    checks++; if (rf_d_q.size() !== NREGS) begin errors++; $display("FAIL ident_rf_count: got %0d want %0d", rf_d_q.size(), NREGS); end
    for (int i = 0; i < NREGS && i < rf_d_q.size(); i++) begin
      checks++;
      if (rf_a_q[i] !== RF_AW'(i) || rf_d_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ident_rf[%0d]: got addr %0d data %0h want addr %0d data %0h", i, rf_a_q[i], rf_d_q[i], i, exp_q[i]);
      end
    end
    bad = 0;
    for (int c = 0; c < NREGS; c++) if (ready_tr[c] !== 1'b0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ident_ready_in_regs: got %0d ready cycles want 0", bad); end
    checks++; if (ready_tr[NREGS] !== 1'b1) begin errors++; $display("FAIL ident_ready_in_inst: got %b want 1", ready_tr[NREGS]); end
    for (int a = 0; a < DEPTH; a++) begin
      e = (a < l) ? w[a] : '0;
      checks++; if (imem_m[a] !== e) begin errors++; $display("FAIL ident_imem[%0d]: got %0h want %0h", a, imem_m[a], e); end
    end
    checks++; if (im_wr_cnt !== DEPTH) begin errors++; $display("FAIL ident_imem_writes: got %0d want %0d", im_wr_cnt, DEPTH); end
    checks++; if (last_im_wr !== r - RST_HOLD) begin errors++; $display("FAIL ident_last_imem_wr: got %0d want %0d", last_im_wr, r - RST_HOLD); end
    checks++; if (first_rst_low() !== r) begin errors++; $display("FAIL ident_core_rst_fall: got %0d want %0d", first_rst_low(), r); end
    bad = 0;
    for (int k = 0; k < RUN_CYCLES; k++) begin
      if (rst_tr[r + k] !== 1'b0 || cc_tr[r + k] !== exp_cc(k)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ident_run_trace: got %0d bad run cycles want 0", bad); end
    checks++; if (inst_count !== (IMEM_AW+1)'(l)) begin errors++; $display("FAIL ident_inst_count: got %0d want %0d", inst_count, l); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ident_ovf: got %b want 0", ovf); end
    checks++; if ({core_rst, busy} !== 2'b10) begin errors++; $display("FAIL ident_done_state: core_rst/busy got %b want 10", {core_rst, busy}); end
    repeat (5) @(negedge clk);
    checks++;
    if (cycle_cnt !== exp_cc(RUN_CYCLES) || inst_count !== (IMEM_AW+1)'(l) || done !== 1'b1) begin
      errors++; $display("FAIL ident_frozen: cycle_cnt=%0d inst_count=%0d done=%b want %0d %0d 1", cycle_cnt, inst_count, done, exp_cc(RUN_CYCLES), l);
    end
  endtask

  task automatic test_stream_regs();
    logic [DATA_W-1:0] rw[$], w[$];
    int l, dc, fall;
    logic [DATA_W-1:0] e;
    l = $urandom_range(3, 12);
    stall_mode = 1;
    push_words(NREGS, 1'b0, rw);
    exp_q = rw;
    push_words(l, 1'b1, w);
    launch(1'b1);
    wait_done(600, dc);
    fall = first_rst_low();
    checks++; if (dc < 0) begin errors++; $display("FAIL stream_done_timeout: got %0d want done", dc); end
    checks++; if (dc - fall !== RUN_CYCLES) begin errors++; $display("FAIL stream_run_len: got %0d want %0d", dc - fall, RUN_CYCLES); end
    checks++; if (rf_d_q.size() !== NREGS) begin errors++; $display("FAIL stream_rf_count: got %0d want %0d", rf_d_q.size(), NREGS); end
    for (int i = 0; i < NREGS && i < rf_d_q.size(); i++) begin
      checks++;
      if (rf_a_q[i] !== RF_AW'(i) || rf_d_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stream_rf[%0d]: got addr %0d data %0h want addr %0d data %0h", i, rf_a_q[i], rf_d_q[i], i, exp_q[i]);
      end
    end
    checks++; if (rf_nohs !== 0) begin errors++; $display("FAIL stream_rf_without_handshake: got %0d want 0", rf_nohs); end
    for (int a = 0; a < DEPTH; a++) begin
      e = (a < l) ? w[a] : '0;
      checks++; if (imem_m[a] !== e) begin errors++; $display("FAIL stream_imem[%0d]: got %0h want %0h", a, imem_m[a], e); end
    end
    checks++; if (inst_count !== (IMEM_AW+1)'(l)) begin errors++; $display("FAIL stream_inst_count: got %0d want %0d", inst_count, l); end
    checks++; if (last_im_wr >= fall) begin errors++; $display("FAIL stream_imem_before_run: got last write %0d want < %0d", last_im_wr, fall); end
    stall_mode = 0;
  endtask

  task automatic test_last_at_end();
    logic [DATA_W-1:0] w[$];
    int dc, r, bad;
    stall_mode = 0;
    push_words(DEPTH, 1'b1, w);
    launch(1'b0);
    wait_done(400, dc);
    r = run_start(DEPTH);
    checks++; if (first_rst_low() !== r) begin errors++; $display("FAIL last_core_rst_fall: got %0d want %0d", first_rst_low(), r); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL last_ovf: got %b want 0", ovf); end
    checks++; if (inst_count !== (IMEM_AW+1)'(DEPTH)) begin errors++; $display("FAIL last_inst_count: got %0d want %0d", inst_count, DEPTH); end
    checks++; if (im_wr_cnt !== DEPTH) begin errors++; $display("FAIL last_imem_writes: got %0d want %0d", im_wr_cnt, DEPTH); end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (imem_m[a] !== w[a]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL last_imem_content: got %0d wrong words want 0", bad); end
    checks++; if (dc !== r + RUN_CYCLES) begin errors++; $display("FAIL last_done_cycle: got %0d want %0d", dc, r + RUN_CYCLES); end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] w[$];
    int dc, r, bad, hold0;
    stall_mode = 0;
    push_words(DEPTH + 4, 1'b0, w);
    launch(1'b0);
    wait_done(400, dc);
    r = run_start(DEPTH + 4);
    hold0 = NREGS + DEPTH;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    checks++; if (im_wr_cnt !== DEPTH) begin errors++; $display("FAIL ovf_imem_writes: got %0d want %0d", im_wr_cnt, DEPTH); end
    checks++; if (inst_count !== (IMEM_AW+1)'(DEPTH)) begin errors++; $display("FAIL ovf_inst_count: got %0d want %0d", inst_count, DEPTH); end
    checks++; if (strm_q.size() !== 4) begin errors++; $display("FAIL ovf_words_left: got %0d want 4", strm_q.size()); end
    checks++; if (ready_tr[hold0 - 1] !== 1'b1) begin errors++; $display("FAIL ovf_ready_last_word: got %b want 1", ready_tr[hold0 - 1]); end
    bad = 0;
    for (int c = hold0; c <= dc && c < TR; c++) if (ready_tr[c] !== 1'b0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_ready_after_full: got %0d ready cycles want 0", bad); end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (imem_m[a] !== w[a]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_imem_content: got %0d wrong words want 0", bad); end
    checks++; if (first_rst_low() !== r) begin errors++; $display("FAIL ovf_no_fill: core_rst fall got %0d want %0d", first_rst_low(), r); end
    flush_stream();
  endtask

  task automatic test_start_in_run();
    logic [DATA_W-1:0] w[$], rw[$];
    int l, r, dc;
    stall_mode = 0;
    l = $urandom_range(1, DEPTH - 1);
    push_words(l, 1'b1, w);
    launch(1'b0);   // from DONE with ovf still set by the previous run
    @(negedge clk); #1;
    checks++;
    if (ovf !== 1'b0 || inst_count !== '0 || cycle_cnt !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_clears: ovf=%b inst_count=%0d cycle_cnt=%0d busy=%b want 0 0 0 1", ovf, inst_count, cycle_cnt, busy);
    end
    r = run_start(l);
    while (cyc < r + 10) @(negedge clk);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(400, dc);
    checks++; if (dc !== r + RUN_CYCLES) begin errors++; $display("FAIL run_start_ignored_done: got %0d want %0d", dc, r + RUN_CYCLES); end
    checks++; if (rf_d_q.size() !== NREGS) begin errors++; $display("FAIL run_start_ignored_rf: got %0d writes want %0d", rf_d_q.size(), NREGS); end
    checks++; if (inst_count !== (IMEM_AW+1)'(l)) begin errors++; $display("FAIL run_start_inst_count: got %0d want %0d", inst_count, l); end

    // second start from DONE, registers from the stream
    l = $urandom_range(1, DEPTH - 1);
    push_words(NREGS, 1'b0, rw);
    exp_q = rw;
    push_words(l, 1'b1, w);
    launch(1'b1);
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || cycle_cnt !== '0 || inst_count !== '0) begin
      errors++; $display("FAIL done_restart_clears: done=%b cycle_cnt=%0d inst_count=%0d want 0 0 0", done, cycle_cnt, inst_count);
    end
    wait_done(400, dc);
    checks++; if (dc !== run_start(l) + RUN_CYCLES) begin errors++; $display("FAIL done_restart_cycle: got %0d want %0d", dc, run_start(l) + RUN_CYCLES); end
    for (int i = 0; i < NREGS && i < rf_d_q.size(); i++) begin
      checks++; if (rf_d_q[i] !== exp_q[i]) begin errors++; $display("FAIL done_restart_rf[%0d]: got %0h want %0h", i, rf_d_q[i], exp_q[i]); end
    end
    checks++; if (imem_m[l - 1] !== w[l - 1]) begin errors++; $display("FAIL done_restart_imem_last: got %0h want %0h", imem_m[l - 1], w[l - 1]); end
  endtask

  task automatic test_rst_in_fill();
    logic [DATA_W-1:0] w[$];
    int dc, l;
    logic [DATA_W-1:0] e;
    stall_mode = 0;
    push_words(5, 1'b1, w);
    launch(1'b0);
    while (cyc < NREGS + 5 + 3) @(negedge clk);
    #2; rst = 1'b0;
    #1;
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_fill_core_rst: got %b want 1", core_rst); end
    checks++;
    if ({busy, done, ovf, s_ready, rf_we, imem_we} !== 6'b0) begin
      errors++; $display("FAIL rst_fill_flags: got %b want 000000", {busy, done, ovf, s_ready, rf_we, imem_we});
    end
    checks++;
    if (inst_count !== '0 || cycle_cnt !== '0) begin
      errors++; $display("FAIL rst_fill_counters: inst_count=%0d cycle_cnt=%0d want 0 0", inst_count, cycle_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    flush_stream();
    repeat (3) @(negedge clk);
    checks++; if ({core_rst, busy} !== 2'b10) begin errors++; $display("FAIL rst_fill_stays_idle: core_rst/busy got %b want 10", {core_rst, busy}); end

    l = $urandom_range(1, DEPTH - 1);
    push_words(l, 1'b1, w);
    launch(1'b0);
    wait_done(400, dc);
    checks++; if (dc !== run_start(l) + RUN_CYCLES) begin errors++; $display("FAIL rst_fill_rerun_done: got %0d want %0d", dc, run_start(l) + RUN_CYCLES); end
    checks++; if (im_wr_cnt !== DEPTH) begin errors++; $display("FAIL rst_fill_rerun_writes: got %0d want %0d", im_wr_cnt, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      e = (a < l) ? w[a] : '0;
      checks++; if (imem_m[a] !== e) begin errors++; $display("FAIL rst_fill_rerun_imem[%0d]: got %0h want %0h", a, imem_m[a], e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0; checks = 0;
    start = 1'b0; reg_src = 1'b0; stall_mode = 0; cyc = TR; rst = 1'b0;
    test_reset();
    test_identity();
    test_stream_regs();
    test_last_at_end();
    test_overflow();
    test_start_in_run();
    test_rst_in_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
